ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single RAM port between two requesters:
  - the instruction fetch path, which supplies the decoder word;
  - the memory-op stage, which performs data loads and stores.
- Serialises their requests and latches address and data.
- Sequences each RAM transaction against a fixed read latency.
- Returns a one-cycle ack to the winner and drives stall flags so the decoder and memory-op stage can freeze.
- Sits between the pipeline and the external ram_* bus. The sys_* bus is out of scope.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RAM_LAT, 1, cycles from the ram_read issue cycle to the cycle ram_r_line is valid. Must be >=1.
- STARVE_MAX, 4, consecutive data grants with f_req pending before fetch is forced to win

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- f_req  in  1  fetch request; held until f_ack
- f_addr  in  ADDR_W  fetch address
- f_ack  out  1  one-cycle pulse; f_data valid this cycle
- f_data  out  DATA_W  fetched word
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle pulse; d_rdata valid this cycle (loads)
- d_rdata  out  DATA_W  load data
- ram_r_addr  out  ADDR_W  RAM read address
- ram_w_addr  out  ADDR_W  RAM write address
- ram_w_line  out  DATA_W  RAM write data
- ram_read  out  1  RAM read strobe
- ram_write  out  1  RAM write strobe
- ram_r_line  in  DATA_W  RAM read data
- stall_fetch  out  1  f_req & ~f_ack
- stall_mem  out  1  d_req & ~d_ack

Behaviour:

Reset (rst=0):
- Asynchronous: state=IDLE, starve count=0.
- All outputs 0, including f_data and d_rdata.
- Reset mid-transaction abandons it. Late ram_r_line is ignored and no ack is issued.

All ram_*, ack and data outputs are registered. The stall flags are combinational from the inputs and the registered acks.

FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: no request → stay. Otherwise pick a winner, latch its addr/we/wdata and identity → ISSUE.
- ISSUE (one cycle, issue cycle T):
  - Read: ram_read=1, ram_r_addr=latched addr; load latency counter with RAM_LAT → WAIT.
  - Write: ram_write=1, ram_w_addr/ram_w_line=latched → ACK.
  - Strobes are high for exactly this one cycle.
- WAIT: counter decrements each cycle. In cycle T+RAM_LAT, capture ram_r_line into f_data or d_rdata (per winner) at the clock edge → ACK.
- ACK (one cycle): pulse the winner's ack; no arbitration this cycle → IDLE.

Latency, request in IDLE at cycle 0:
- Read: ram_read in cycle 1, ack in cycle RAM_LAT+2.
- Write: ram_write in cycle 1, ack in cycle 2.
- Minimum spacing between grants is 3 cycles for writes and RAM_LAT+3 for reads.

Arbitration (IDLE only):
- Data beats fetch, unless starve count == STARVE_MAX and f_req=1; then fetch wins.
- Starve count update:
  - increments (saturating at STARVE_MAX) on each data grant while f_req=1;
  - clears on a fetch grant;
  - clears on any IDLE arbitration with f_req=0.

Boundary rules:
- Simultaneous requests are resolved purely by the rule above.
- f_data and d_rdata hold their last value until overwritten.
- Requests and operands are sampled only in IDLE. Later changes are ignored until ack.
- A requester dropping req before ack does not cancel the transaction; the ack still pulses.
- A write never alters f_data or d_rdata.

Decomposition:
- Shared header ram_arb_defs.v holds:
  - state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, ACK=2'd3);
  - winner codes (WIN_F=1'b0, WIN_D=1'b1).
- Sub-module arb_starve_ctl: combinational winner select plus the saturating starve counter, parameterised by STARVE_MAX. Everything else is in the top level.

Test Plan:
1. Reset, then f_req=1, f_addr=0x100, RAM model returns 0xDEADBEEF at LAT=1 → ram_read=1 with ram_r_addr=0x100 in cycle 1; f_ack=1 and f_data=0xDEADBEEF in cycle 3; stall_fetch=1 in cycles 0–2.
2. d_req=1, d_we=1, d_addr=0x40, d_wdata=0x12345678 → ram_write=1 with ram_w_addr=0x40 and ram_w_line=0x12345678 in cycle 1 only; d_ack in cycle 2; d_rdata unchanged.
3. f_req and d_req (load) both asserted in the same cycle → data is served first; the fetch is issued after the data ack; stall_fetch stays high throughout.
4. f_req held while d_req is re-asserted back-to-back (STARVE_MAX=4) → grants are D,D,D,D,F,D…; the starve counter clears after the F grant.
5. RAM_LAT=3, read to 0x200 → ram_read in cycle 1, data captured from cycle 4, ack in cycle 5. rst=0 asserted in cycle 3 → all outputs 0 immediately and no ack after release.
6. Requester drops d_req in ISSUE → d_ack still pulses once, and the FSM returns to IDLE and serves a pending f_req next.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the RAM port arbiter: FSM state encodings and winner codes.
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  typedef enum logic {
    WIN_F = 1'b0,
    WIN_D = 1'b1
  } arb_win_t;

endpackage

// File: rtl/ram_port_arbiter_arb_starve_ctl.sv
// Winner select for the shared RAM port: data has priority, but a fetch that has
// watched STARVE_MAX consecutive data grants is forced through.
module arb_starve_ctl
  import ram_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_arb_en,
  input  logic     i_f_req,
  input  logic     i_d_req,
  output arb_win_t o_win
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_force_f;

  assign w_force_f = i_f_req && (r_cnt == CNT_W'(STARVE_MAX));
  assign o_win     = (i_d_req && !w_force_f) ? WIN_D : WIN_F;

  // Count only data grants that passed over a waiting fetch; any fetch grant or
  // an arbitration without a fetch pending starts the count over.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_arb_en) begin
      if (!i_f_req || (o_win == WIN_F)) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_W'(STARVE_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between instruction fetch and the memory-op stage,
// sequencing each access against a fixed read latency and acking the winner.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_data,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_r_addr,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [DATA_W-1:0] ram_w_line,
  output logic              ram_read,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_r_line,
  output logic              stall_fetch,
  output logic              stall_mem
);

  localparam int LAT_W = $clog2(RAM_LAT + 1);

  arb_state_t        r_state;
  arb_state_t        w_next;
  arb_win_t          r_win;
  arb_win_t          w_win;
  logic              r_we;
  logic [LAT_W-1:0]  r_lat;
  logic              r_f_ack;
  logic              r_d_ack;
  logic [DATA_W-1:0] r_f_data;
  logic [DATA_W-1:0] r_d_rdata;
  logic [ADDR_W-1:0] r_ram_r_addr;
  logic [ADDR_W-1:0] r_ram_w_addr;
  logic [DATA_W-1:0] r_ram_w_line;
  logic              r_ram_read;
  logic              r_ram_write;
  logic              w_idle;
  logic              w_any_req;
  logic              w_lat_done;

  assign w_idle     = (r_state == IDLE);
  assign w_any_req  = f_req | d_req;
  assign w_lat_done = (r_lat == LAT_W'(1));

  arb_starve_ctl #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .i_arb_en(w_idle),
    .i_f_req (f_req),
    .i_d_req (d_req),
    .o_win   (w_win)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next = ISSUE;
      ISSUE:   w_next = r_we ? ACK : WAIT;
      WAIT:    if (w_lat_done) w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // The strobe registers are loaded on the grant edge so the strobe is visible
  // during ISSUE; address/data registers double as the latched operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win        <= WIN_F;
      r_we         <= 1'b0;
      r_lat        <= '0;
      r_f_ack      <= 1'b0;
      r_d_ack      <= 1'b0;
      r_f_data     <= '0;
      r_d_rdata    <= '0;
      r_ram_r_addr <= '0;
      r_ram_w_addr <= '0;
      r_ram_w_line <= '0;
      r_ram_read   <= 1'b0;
      r_ram_write  <= 1'b0;
    end else begin
      r_ram_read  <= 1'b0;
      r_ram_write <= 1'b0;
      r_f_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_win <= w_win;
            if (w_win == WIN_D) begin
              r_we <= d_we;
              if (d_we) begin
                r_ram_write  <= 1'b1;
                r_ram_w_addr <= d_addr;
                r_ram_w_line <= d_wdata;
              end else begin
                r_ram_read   <= 1'b1;
                r_ram_r_addr <= d_addr;
              end
            end else begin
              r_we         <= 1'b0;
              r_ram_read   <= 1'b1;
              r_ram_r_addr <= f_addr;
            end
          end
        end
        ISSUE: begin
          r_lat <= LAT_W'(RAM_LAT);
          if (r_we) r_d_ack <= 1'b1;
        end
        WAIT: begin
          if (w_lat_done) begin
            if (r_win == WIN_D) begin
              r_d_rdata <= ram_r_line;
              r_d_ack   <= 1'b1;
            end else begin
              r_f_data  <= ram_r_line;
              r_f_ack   <= 1'b1;
            end
          end else begin
            r_lat <= r_lat - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign f_ack      = r_f_ack;
  assign d_ack      = r_d_ack;
  assign f_data     = r_f_data;
  assign d_rdata    = r_d_rdata;
  assign ram_r_addr = r_ram_r_addr;
  assign ram_w_addr = r_ram_w_addr;
  assign ram_w_line = r_ram_w_line;
  assign ram_read   = r_ram_read;
  assign ram_write  = r_ram_write;

  // Gated by reset so every output reads zero while reset is held.
  assign stall_fetch = rst & f_req & ~r_f_ack;
  assign stall_mem   = rst & d_req & ~r_d_ack;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized scoreboard bench for ram_port_arbiter: two requester drivers, a RAM
// model, and a monitor that checks grants, latencies and returned data.
`timescale 1ns/1ps
module tb_ram_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 4;
  localparam int NF   = 60;
  localparam int ND   = 120;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          f_ack;
  logic [DW-1:0] f_data;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] ram_r_addr;
  logic [AW-1:0] ram_w_addr;
  logic [DW-1:0] ram_w_line;
  logic          ram_read;
  logic          ram_write;
  logic [DW-1:0] ram_r_line = '0;
  logic          stall_fetch;
  logic          stall_mem;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_data(f_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .ram_r_addr(ram_r_addr), .ram_w_addr(ram_w_addr), .ram_w_line(ram_w_line),
    .ram_read(ram_read), .ram_write(ram_write), .ram_r_line(ram_r_line),
    .stall_fetch(stall_fetch), .stall_mem(stall_mem)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Fetch region is never written, so its contents are a fixed function of address.
  function automatic logic [31:0] romWord(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // RAM model: returns the word exactly LAT cycles after the read strobe,
  // noise on every other cycle.
  typedef struct { logic [31:0] addr; int due; } rd_t;
  logic [31:0] ramMem [logic [31:0]];
  rd_t         rdPend[$];

  always @(posedge clk) begin
    logic [31:0] a;
    #1;
    if (ram_write) ramMem[ram_w_addr] = ram_w_line;
    if (ram_read) rdPend.push_back('{ram_r_addr, cyc + LAT});
    while (rdPend.size() > 0 && rdPend[0].due < cyc) void'(rdPend.pop_front());
    ram_r_line = $urandom;
    if (rdPend.size() > 0 && rdPend[0].due == cyc) begin
      a = rdPend[0].addr;
      void'(rdPend.pop_front());
      ram_r_line = ramMem.exists(a) ? ramMem[a] : romWord(a);
    end
  end

  // Scoreboard state: expected transactions per requester, the one in flight,
  // and the starvation history seen from the requesters' side.
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; } exp_t;
  exp_t        fQ[$];
  exp_t        dQ[$];
  logic [31:0] refMem [logic [31:0]];
  logic        checkEn = 1'b0;
  logic        inBusy = 1'b0;
  exp_t        inExp;
  logic        inWho = 1'b0;
  int          inDue = 0;
  logic        fGranted = 1'b0, dGranted = 1'b0, fAcked = 1'b0, dAcked = 1'b0;
  logic [31:0] lastF = '0, lastD = '0;
  int          starve = 0;
  int          forcedHits = 0;
  logic        prevF = 1'b0, prevD = 1'b0;

  always @(negedge clk) begin
    logic ackNow;
    logic strobe;
    logic idleNow;
    logic expD;
    exp_t e;
    if (checkEn) begin
      ackNow  = f_ack | d_ack;
      strobe  = ram_read | ram_write;
      idleNow = !inBusy && !ackNow && !strobe;
      checkOutput("stall_fetch", stall_fetch, f_req & ~f_ack);
      checkOutput("stall_mem", stall_mem, d_req & ~d_ack);
      if (idleNow && !f_req) starve = 0;
      if (ackNow) begin
        if (!inBusy) begin
          checkOutput("spurious_ack", {f_ack, d_ack}, 2'b00);
        end else begin
          checkOutput("ack_cycle", cyc, inDue);
          checkOutput("ack_who", {f_ack, d_ack}, inWho ? 2'b01 : 2'b10);
          if (!inWho) lastF = inExp.rdata;
          else if (!inExp.we) lastD = inExp.rdata;
          checkOutput("f_data", f_data, lastF);
          checkOutput("d_rdata", d_rdata, lastD);
          if (inWho) dAcked = 1'b1; else fAcked = 1'b1;
          inBusy = 1'b0;
        end
      end else if (inBusy && cyc >= inDue) begin
        checkOutput("ack_missing", {f_ack, d_ack}, inWho ? 2'b01 : 2'b10);
        if (inWho) dAcked = 1'b1; else fAcked = 1'b1;
        inBusy = 1'b0;
      end
      if (strobe) begin
        expD = prevD && !(prevF && starve == SMAX);
        if (prevF && prevD && !expD) forcedHits++;
        if (expD && prevF) begin
          if (starve < SMAX) starve++;
        end else begin
          starve = 0;
        end
        checkOutput("strobe_exclusive", ram_read & ram_write, 1'b0);
        checkOutput("grant_while_busy", inBusy, 1'b0);
        if (expD ? (dQ.size() == 0) : (fQ.size() == 0)) begin
          checkOutput("grant_without_request", strobe, 1'b0);
        end else begin
          e = expD ? dQ.pop_front() : fQ.pop_front();
          checkOutput("ram_read", ram_read, !e.we);
          checkOutput("ram_write", ram_write, e.we);
          if (e.we) begin
            checkOutput("ram_w_addr", ram_w_addr, e.addr);
            checkOutput("ram_w_line", ram_w_line, e.wdata);
          end else begin
            checkOutput("ram_r_addr", ram_r_addr, e.addr);
          end
          inBusy = 1'b1;
          inExp  = e;
          inWho  = expD;
          inDue  = cyc + (e.we ? 1 : LAT + 1);
          if (expD) dGranted = 1'b1; else fGranted = 1'b1;
        end
      end
      prevF = f_req;
      prevD = d_req;
    end
  end

  // Both requesters run concurrently; each holds its request until acked and
  // sometimes drops it or scrambles operands after being granted.
  task automatic applyStimulus();
    fork
      begin
        for (int i = 0; i < NF; i++) begin
          int gap;
          int n;
          logic [31:0] a;
          logic dropIt;
          gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
          repeat (gap) begin @(posedge clk); #1; end
          a = 32'h1000 + 4 * $urandom_range(0, 63);
          dropIt = ($urandom_range(0, 4) == 0);
          fQ.push_back('{1'b0, a, 32'h0, romWord(a)});
          fAcked = 1'b0; fGranted = 1'b0;
          f_req = 1'b1; f_addr = a;
          n = 0;
          while (!fAcked && n < 200) begin
            @(posedge clk); #1; n++;
            if (fGranted) begin
              f_addr = $urandom;
              if (dropIt) f_req = 1'b0;
            end
          end
          checkOutput("f_ack_timeout", fAcked, 1'b1);
          f_req = 1'b0;
        end
      end
      begin
        for (int i = 0; i < ND; i++) begin
          int gap;
          int n;
          logic [31:0] a;
          logic [31:0] w;
          logic we;
          logic dropIt;
          gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
          repeat (gap) begin @(posedge clk); #1; end
          a  = 4 * $urandom_range(0, 15);
          w  = $urandom;
          we = $urandom_range(0, 1);
          dropIt = ($urandom_range(0, 3) == 0);
          if (we) begin
            refMem[a] = w;
            dQ.push_back('{1'b1, a, w, 32'h0});
          end else begin
            dQ.push_back('{1'b0, a, 32'h0, refMem.exists(a) ? refMem[a] : romWord(a)});
          end
          dAcked = 1'b0; dGranted = 1'b0;
          d_req = 1'b1; d_we = we; d_addr = a; d_wdata = w;
          n = 0;
          while (!dAcked && n < 200) begin
            @(posedge clk); #1; n++;
            if (dGranted) begin
              d_addr = $urandom; d_wdata = $urandom; d_we = $urandom_range(0, 1);
              if (dropIt) d_req = 1'b0;
            end
          end
          checkOutput("d_ack_timeout", dAcked, 1'b1);
          d_req = 1'b0;
        end
      end
    join
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ackCount;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ram_read", ram_read, 1'b0);
    checkOutput("reset_ram_write", ram_write, 1'b0);
    checkOutput("reset_f_ack", f_ack, 1'b0);
    checkOutput("reset_d_ack", d_ack, 1'b0);
    checkOutput("reset_f_data", f_data, 32'h0);
    checkOutput("reset_d_rdata", d_rdata, 32'h0);
    checkOutput("reset_ram_r_addr", ram_r_addr, 32'h0);
    checkOutput("reset_ram_w_addr", ram_w_addr, 32'h0);
    checkOutput("reset_ram_w_line", ram_w_line, 32'h0);
    checkOutput("reset_stall_fetch", stall_fetch, 1'b0);
    checkOutput("reset_stall_mem", stall_mem, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkEn = 1'b1;

    applyStimulus();

    repeat (8) begin @(posedge clk); #1; end
    checkOutput("fetch_queue_drained", fQ.size(), 0);
    checkOutput("data_queue_drained", dQ.size(), 0);
    checkOutput("starvation_override_seen", (forcedHits > 0), 1'b1);
    checkOutput("nothing_in_flight", inBusy, 1'b0);
    checkEn = 1'b0;

    // Reset during the WAIT phase of a fetch: the read must be abandoned.
    f_addr = 32'h1010; f_req = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_ram_read", ram_read, 1'b1);
    checkOutput("midrst_ram_r_addr", ram_r_addr, 32'h1010);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("midrst_f_ack", f_ack, 1'b0);
    checkOutput("midrst_d_ack", d_ack, 1'b0);
    checkOutput("midrst_f_data", f_data, 32'h0);
    checkOutput("midrst_d_rdata", d_rdata, 32'h0);
    checkOutput("midrst_ram_read", ram_read, 1'b0);
    checkOutput("midrst_ram_write", ram_write, 1'b0);
    checkOutput("midrst_ram_r_addr", ram_r_addr, 32'h0);
    checkOutput("midrst_ram_w_line", ram_w_line, 32'h0);
    f_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    ackCount = 0;
    repeat (10) begin
      @(negedge clk);
      if (f_ack | d_ack) ackCount++;
    end
    checkOutput("no_ack_after_reset", ackCount, 0);
    checkOutput("f_data_after_reset", f_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
